sincronizador_n: RTL and testbench
==================================

SINCRONIZADOR_N -- requirements
Module: sincronizador_n

Interface
REQ-001 Parameter N_COMMAS, default 3, number of even-aligned commas needed to acquire sync (range 1..15).
REQ-002 Parameter MAX_BAD_LVL, default 3, highest bad-level reached before sync is lost (range 1..7).
REQ-003 Parameter N_GOOD, default 4, consecutive good code-groups required to lower the bad-level by one (range 1..15).
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 rx_code_group  in  10  received 8b/10b code-group, bit 9 = 'a', bit 0 = 'j'.
REQ-007 rx_invalid  in  1  upstream decoder flag, 1 = current code-group not in the valid 8b/10b set.
REQ-008 rx_code_group_out  out  10  rx_code_group delayed one cycle.
REQ-009 code_status  out  1  1 = link synchronized.
REQ-010 rx_even  out  1  parity of the code-group currently on rx_code_group_out, 1 = even.
REQ-011 bad_level  out  3  current bad-level while synchronized, 0 otherwise.

Function
REQ-012 Comma = rx_code_group[9:3] equal to 0011111 or 1100000, evaluated combinationally on the input.
REQ-013 Bad code-group = rx_invalid high, or comma while the next parity would be odd.
REQ-014 FSM states: LOSS_OF_SYNC, COMMA_DETECT, ACQUIRE_SYNC, SYNC_ACQUIRED; each transition evaluates the input present at that edge.
REQ-015 LOSS_OF_SYNC: rx_even toggles each cycle; comma -> COMMA_DETECT, comma_cnt=1, rx_even=1; any other input -> stay.
REQ-016 COMMA_DETECT: rx_invalid or comma -> LOSS_OF_SYNC; valid non-comma with comma_cnt==N_COMMAS -> SYNC_ACQUIRED, bad_level=0, good_cnt=0; otherwise -> ACQUIRE_SYNC; rx_even=0 in all non-loss cases.
REQ-017 ACQUIRE_SYNC: rx_even toggles; comma at even position -> COMMA_DETECT, comma_cnt+1, rx_even=1; bad code-group -> LOSS_OF_SYNC; valid non-comma -> stay.
REQ-018 SYNC_ACQUIRED: rx_even toggles; bad code-group with bad_level==MAX_BAD_LVL -> LOSS_OF_SYNC; bad code-group otherwise -> bad_level+1, good_cnt=0.
REQ-019 SYNC_ACQUIRED good code-group with bad_level>0: good_cnt+1; when good_cnt reaches N_GOOD -> bad_level-1, good_cnt=0; with bad_level==0 good_cnt holds at 0.
REQ-020 code_status = 1 exactly when the registered state is SYNC_ACQUIRED; first high cycle is the one after the edge that accepts the valid data following the N_COMMAS-th comma.
REQ-021 Entering LOSS_OF_SYNC clears comma_cnt, good_cnt, bad_level in the same edge.
REQ-022 All outputs registered; no combinational path from inputs to outputs; latency 1 cycle.
REQ-023 Counters saturate, never wrap; comma_cnt never exceeds N_COMMAS.

Reset
REQ-024 RESET high at a rising edge: state=LOSS_OF_SYNC, code_status=0, rx_even=0, bad_level=0, rx_code_group_out=0, all counters 0.
REQ-025 RESET asserted mid-acquisition or while synchronized takes priority over every transition in that cycle.
REQ-026 First input evaluated is the one present at the first edge with RESET low.

Structure
REQ-027 State encodings and the two comma patterns belong in a shared package, sincronizador_pkg.
REQ-028 Comma detector is one sub-module, comma_det (10-bit in, 1-bit out, combinational).
REQ-029 Parameter legality checked at elaboration; illegal value stops elaboration.

Verification
REQ-030 Reset, then K28.5 (0011111010), D16.2, K28.5, D16.2, K28.5, D16.2 -> code_status rises one cycle after the third D16.2 edge; bad_level=0.
REQ-031 Synchronized, 4 rx_invalid cycles -> bad_level 1,2,3, then code_status=0 after the 4th.
REQ-032 Synchronized, 1 rx_invalid then 4 valid D-groups -> bad_level 1 then 0; code_status stays 1.
REQ-033 During ACQUIRE_SYNC, comma at odd position -> LOSS_OF_SYNC, comma_cnt cleared, code_status stays 0.
REQ-034 RESET pulsed while synchronized -> next cycle all outputs 0, reacquisition requires full comma sequence.
REQ-035 N_COMMAS=1, N_GOOD=2 build -> sync after one comma plus one valid group; recovery after 2 good groups.

Source files
------------

// File: rtl/sincronizador_pkg.sv
// Shared types and constants for the 8b/10b code-group synchronizer:
// FSM state encoding, comma patterns, debug view and a saturating counter helper.
package sincronizador_pkg;

    localparam int CG_W  = 10;
    localparam int CNT_W = 4;
    localparam int LVL_W = 3;

    // Seven-bit comma prefix (bits a..g) in both running disparities.
    localparam logic [6:0] COMMA_POS = 7'b0011111;
    localparam logic [6:0] COMMA_NEG = 7'b1100000;

    typedef enum logic [1:0] {
        LOSS_OF_SYNC  = 2'd0,
        COMMA_DETECT  = 2'd1,
        ACQUIRE_SYNC  = 2'd2,
        SYNC_ACQUIRED = 2'd3
    } sync_state_t;

    typedef struct packed {
        sync_state_t      state;
        logic [CNT_W-1:0] comma_cnt;
        logic [CNT_W-1:0] good_cnt;
    } sync_dbg_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v < lim) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/sincronizador_n_if.sv
// Code-group stream into the synchronizer and its registered status back out.
// One code-group per clock, no back-pressure: there is no valid/ready pair, every cycle carries data.
interface sincronizador_n_if;
    import sincronizador_pkg::*;

    logic [CG_W-1:0]  rx_code_group;
    logic             rx_invalid;
    logic [CG_W-1:0]  rx_code_group_out;
    logic             code_status;
    logic             rx_even;
    logic [LVL_W-1:0] bad_level;

    modport master (
        output rx_code_group, rx_invalid,
        input  rx_code_group_out, code_status, rx_even, bad_level
    );

    modport slave (
        input  rx_code_group, rx_invalid,
        output rx_code_group_out, code_status, rx_even, bad_level
    );

endinterface

// File: rtl/sincronizador_n_comma_det.sv
// Combinational comma detector: flags a code-group whose a..g bits match either comma polarity.
module comma_det
    import sincronizador_pkg::*;
(
    input  logic [CG_W-1:0] code_group,
    output logic            comma
);

    logic [6:0] prefix;

    assign prefix = code_group[CG_W-1:CG_W-7];
    assign comma  = (prefix == COMMA_POS) || (prefix == COMMA_NEG);

endmodule

// File: rtl/sincronizador_n.sv
// 8b/10b receive synchronization FSM: acquires alignment on even-position commas and
// tracks link quality with a bad-level that rises on bad code-groups and decays on good runs.
module sincronizador_n
    import sincronizador_pkg::*;
#(
    parameter int N_COMMAS    = 3,
    parameter int MAX_BAD_LVL = 3,
    parameter int N_GOOD      = 4
) (
    input  logic             clk,
    input  logic             RESET,
    sincronizador_n_if.slave bus,
    output sync_dbg_t        dbg
);

    if (N_COMMAS < 1 || N_COMMAS > 15) begin : g_bad_n_commas
        $error("sincronizador_n: N_COMMAS must be in 1..15");
    end
    if (MAX_BAD_LVL < 1 || MAX_BAD_LVL > 7) begin : g_bad_max_bad_lvl
        $error("sincronizador_n: MAX_BAD_LVL must be in 1..7");
    end
    if (N_GOOD < 1 || N_GOOD > 15) begin : g_bad_n_good
        $error("sincronizador_n: N_GOOD must be in 1..15");
    end

    localparam logic [CNT_W-1:0] N_COMMAS_C = CNT_W'(N_COMMAS);
    localparam logic [CNT_W-1:0] N_GOOD_C   = CNT_W'(N_GOOD);
    localparam logic [LVL_W-1:0] MAX_BAD_C  = LVL_W'(MAX_BAD_LVL);

    logic comma;

    comma_det u_comma_det (
        .code_group (bus.rx_code_group),
        .comma      (comma)
    );

    sync_state_t      state_q, state_d;
    logic [CNT_W-1:0] comma_cnt_q, comma_cnt_d;
    logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
    logic [LVL_W-1:0] bad_level_q, bad_level_d;
    logic             rx_even_q, rx_even_d;
    logic             code_status_q, code_status_d;
    logic [CG_W-1:0]  rx_code_group_out_q, rx_code_group_out_d;

    logic             next_even;
    logic             bad_cg;
    logic [CNT_W-1:0] good_inc;

    always_comb begin
        // A comma only counts as good when it would land on an even position.
        next_even           = ~rx_even_q;
        bad_cg              = bus.rx_invalid | (comma & ~next_even);
        good_inc            = good_cnt_q + 1'b1;

        state_d             = state_q;
        comma_cnt_d         = comma_cnt_q;
        good_cnt_d          = good_cnt_q;
        bad_level_d         = bad_level_q;
        rx_even_d           = next_even;
        rx_code_group_out_d = bus.rx_code_group;

        case (state_q)
            LOSS_OF_SYNC: begin
                if (comma) begin
                    state_d     = COMMA_DETECT;
                    comma_cnt_d = CNT_W'(1);
                    rx_even_d   = 1'b1;
                end
            end
            COMMA_DETECT: begin
                rx_even_d = 1'b0;
                if (bus.rx_invalid || comma) begin
                    state_d = LOSS_OF_SYNC;
                end else if (comma_cnt_q == N_COMMAS_C) begin
                    state_d     = SYNC_ACQUIRED;
                    bad_level_d = '0;
                    good_cnt_d  = '0;
                end else begin
                    state_d = ACQUIRE_SYNC;
                end
            end
            ACQUIRE_SYNC: begin
                if (bad_cg) begin
                    state_d = LOSS_OF_SYNC;
                end else if (comma) begin
                    state_d     = COMMA_DETECT;
                    comma_cnt_d = sat_inc(comma_cnt_q, N_COMMAS_C);
                    rx_even_d   = 1'b1;
                end
            end
            SYNC_ACQUIRED: begin
                if (bad_cg) begin
                    if (bad_level_q == MAX_BAD_C) begin
                        state_d = LOSS_OF_SYNC;
                    end else begin
                        bad_level_d = bad_level_q + 1'b1;
                        good_cnt_d  = '0;
                    end
                end else if (bad_level_q != '0) begin
                    // A full run of good groups pays back one bad-level step.
                    if (good_inc == N_GOOD_C) begin
                        bad_level_d = bad_level_q - 1'b1;
                        good_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end else begin
                    good_cnt_d = '0;
                end
            end
            default: state_d = LOSS_OF_SYNC;
        endcase

        if (state_d == LOSS_OF_SYNC) begin
            comma_cnt_d = '0;
            good_cnt_d  = '0;
            bad_level_d = '0;
        end

        code_status_d = (state_d == SYNC_ACQUIRED);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q             <= LOSS_OF_SYNC;
            comma_cnt_q         <= '0;
            good_cnt_q          <= '0;
            bad_level_q         <= '0;
            rx_even_q           <= 1'b0;
            code_status_q       <= 1'b0;
            rx_code_group_out_q <= '0;
        end else begin
            state_q             <= state_d;
            comma_cnt_q         <= comma_cnt_d;
            good_cnt_q          <= good_cnt_d;
            bad_level_q         <= bad_level_d;
            rx_even_q           <= rx_even_d;
            code_status_q       <= code_status_d;
            rx_code_group_out_q <= rx_code_group_out_d;
        end
    end

    assign bus.rx_code_group_out = rx_code_group_out_q;
    assign bus.code_status       = code_status_q;
    assign bus.rx_even           = rx_even_q;
    assign bus.bad_level         = bad_level_q;

    assign dbg.state     = state_q;
    assign dbg.comma_cnt = comma_cnt_q;
    assign dbg.good_cnt  = good_cnt_q;

endmodule

// File: tb/tb_sincronizador_n.sv
// Bench for sincronizador_n: default build (a) and N_COMMAS=1/N_GOOD=2 build (b),
// scenario tasks with an expected-value queue of {code_status, bad_level, rx_even, rx_code_group_out}.
module tb_sincronizador_n;
    import sincronizador_pkg::*;

    localparam logic [9:0] K_NEG = 10'b0011111010;
    localparam logic [9:0] K_POS = 10'b1100000101;
    localparam logic [9:0] D16_2 = 10'b0110110101;
    localparam logic [9:0] D21_5 = 10'b1010101010;

    logic      clk;
    logic      RESET;
    sync_dbg_t dbg_a, dbg_b;

    sincronizador_n_if bus_a ();
    sincronizador_n_if bus_b ();

    sincronizador_n dut_a (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus_a),
        .dbg   (dbg_a)
    );

    sincronizador_n #(.N_COMMAS(1), .MAX_BAD_LVL(3), .N_GOOD(2)) dut_b (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus_b),
        .dbg   (dbg_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] exp_q[$];
    int          n_pass;
    int          n_total;

    function automatic logic [14:0] ex(input logic st, input logic [2:0] bad,
                                       input logic ev, input logic [9:0] cg);
        return {st, bad, ev, cg};
    endfunction

    function automatic logic [14:0] obs_a();
        return {bus_a.code_status, bus_a.bad_level, bus_a.rx_even, bus_a.rx_code_group_out};
    endfunction

    function automatic logic [14:0] obs_b();
        return {bus_b.code_status, bus_b.bad_level, bus_b.rx_even, bus_b.rx_code_group_out};
    endfunction

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        RESET               = 1'b1;
        bus_a.rx_code_group = K_NEG;
        bus_a.rx_invalid    = 1'b0;
        bus_b.rx_code_group = K_NEG;
        bus_b.rx_invalid    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input bit sel_b, input logic [9:0] cg, input logic inv);
        @(negedge clk);
        RESET = 1'b0;
        if (sel_b) begin
            bus_b.rx_code_group = cg;
            bus_b.rx_invalid    = inv;
        end else begin
            bus_a.rx_code_group = cg;
            bus_a.rx_invalid    = inv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go_sync();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b0, K_NEG, 1'b0);
            drive_in(1'b0, D16_2, 1'b0);
        end
    endtask

    // scenarios
    task automatic test_reset();
        logic [14:0] e;
        exp_q.push_back(15'd0);
        exp_q.push_back(15'd0);
        do_reset();
        do_reset();
        e = exp_q.pop_front();
        n_total++;
        if (obs_a() !== e) $display("FAIL reset_a: got %h, expected %h", obs_a(), e);
        else n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if (obs_b() !== e) $display("FAIL reset_b: got %h, expected %h", obs_b(), e);
        else n_pass++;
        n_total++;
        if (dbg_a.state !== LOSS_OF_SYNC || dbg_a.comma_cnt !== 4'd0 || dbg_a.good_cnt !== 4'd0)
            $display("FAIL reset_dbg: got state %0d cc %0d gc %0d, expected 0 0 0",
                     dbg_a.state, dbg_a.comma_cnt, dbg_a.good_cnt);
        else n_pass++;
        // first edge with RESET low already evaluates its input
        exp_q.push_back(ex(1'b0, 3'd0, 1'b1, K_NEG));
        drive_in(1'b0, K_NEG, 1'b0);
        e = exp_q.pop_front();
        n_total++;
        if (obs_a() !== e) $display("FAIL reset_first_input: got %h, expected %h", obs_a(), e);
        else n_pass++;
    endtask

    task automatic test_acquire();
        logic [9:0]  cg_t [6] = '{K_NEG, D16_2, K_NEG, D16_2, K_NEG, D16_2};
        logic [5:0]  st_v = 6'b100000;
        logic [5:0]  ev_v = 6'b010101;
        logic [14:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ex(st_v[i], 3'd0, ev_v[i], cg_t[i]));
            drive_in(1'b0, cg_t[i], 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if (obs_a() !== e) $display("FAIL acquire[%0d]: got %h, expected %h", i, obs_a(), e);
            else n_pass++;
        end
        n_total++;
        if (dbg_a.state !== SYNC_ACQUIRED || dbg_a.comma_cnt !== 4'd3)
            $display("FAIL acquire_dbg: got state %0d cc %0d, expected 3 3", dbg_a.state, dbg_a.comma_cnt);
        else n_pass++;
    endtask

    task automatic test_bad_level();
        logic [2:0]  bad_t [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
        logic [3:0]  st_v = 4'b0111;
        logic [3:0]  ev_v = 4'b0101;
        logic [14:0] e;
        go_sync();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ex(st_v[i], bad_t[i], ev_v[i], D16_2));
            drive_in(1'b0, D16_2, 1'b1);
            e = exp_q.pop_front();
            n_total++;
            if (obs_a() !== e) $display("FAIL bad_level[%0d]: got %h, expected %h", i, obs_a(), e);
            else n_pass++;
        end
        n_total++;
        if (dbg_a.state !== LOSS_OF_SYNC || dbg_a.comma_cnt !== 4'd0 || dbg_a.good_cnt !== 4'd0)
            $display("FAIL bad_level_dbg: got state %0d cc %0d gc %0d, expected 0 0 0",
                     dbg_a.state, dbg_a.comma_cnt, dbg_a.good_cnt);
        else n_pass++;
    endtask

    task automatic test_recovery();
        logic [9:0]  cg_t [8] = '{D16_2, D16_2, D21_5, D16_2, D16_2, D21_5, K_NEG, K_POS};
        logic [2:0]  bad_t [8] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1};
        logic [7:0]  inv_v = 8'b00000001;
        logic [7:0]  ev_v  = 8'b01010101;
        logic [14:0] e;
        go_sync();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(ex(1'b1, bad_t[i], ev_v[i], cg_t[i]));
            drive_in(1'b0, cg_t[i], inv_v[i]);
            e = exp_q.pop_front();
            n_total++;
            if (obs_a() !== e) $display("FAIL recovery[%0d]: got %h, expected %h", i, obs_a(), e);
            else n_pass++;
        end
        n_total++;
        if (dbg_a.good_cnt !== 4'd0)
            $display("FAIL recovery_good_cnt: got %0d, expected 0", dbg_a.good_cnt);
        else n_pass++;
    endtask

    task automatic test_odd_comma();
        logic [9:0]  cg_t [6] = '{K_NEG, D16_2, D16_2, K_NEG, K_NEG, K_POS};
        logic [5:0]  ev_v = 6'b010101;
        logic [14:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ex(1'b0, 3'd0, ev_v[i], cg_t[i]));
            drive_in(1'b0, cg_t[i], 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if (obs_a() !== e) $display("FAIL odd_comma[%0d]: got %h, expected %h", i, obs_a(), e);
            else n_pass++;
            if (i == 3) begin
                n_total++;
                if (dbg_a.state !== LOSS_OF_SYNC || dbg_a.comma_cnt !== 4'd0)
                    $display("FAIL odd_comma_loss: got state %0d cc %0d, expected 0 0",
                             dbg_a.state, dbg_a.comma_cnt);
                else n_pass++;
            end
            if (i == 4) begin
                n_total++;
                if (dbg_a.state !== COMMA_DETECT || dbg_a.comma_cnt !== 4'd1)
                    $display("FAIL odd_comma_restart: got state %0d cc %0d, expected 1 1",
                             dbg_a.state, dbg_a.comma_cnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_sync();
        logic [9:0]  cg_t [6] = '{K_NEG, D16_2, K_POS, D21_5, K_NEG, D16_2};
        logic [5:0]  st_v = 6'b100000;
        logic [5:0]  ev_v = 6'b010101;
        logic [14:0] e;
        go_sync();
        exp_q.push_back(15'd0);
        do_reset();
        e = exp_q.pop_front();
        n_total++;
        if (obs_a() !== e) $display("FAIL reset_sync: got %h, expected %h", obs_a(), e);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ex(st_v[i], 3'd0, ev_v[i], cg_t[i]));
            drive_in(1'b0, cg_t[i], 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if (obs_a() !== e) $display("FAIL reacquire[%0d]: got %h, expected %h", i, obs_a(), e);
            else n_pass++;
        end
    endtask

    task automatic test_n1_build();
        logic [9:0]  cg_t [6] = '{K_NEG, D16_2, D16_2, D21_5, D16_2, D21_5};
        logic [2:0]  bad_t [6] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
        logic [5:0]  st_v  = 6'b111110;
        logic [5:0]  ev_v  = 6'b010101;
        logic [5:0]  inv_v = 6'b000100;
        logic [14:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ex(st_v[i], bad_t[i], ev_v[i], cg_t[i]));
            drive_in(1'b1, cg_t[i], inv_v[i]);
            e = exp_q.pop_front();
            n_total++;
            if (obs_b() !== e) $display("FAIL n1_build[%0d]: got %h, expected %h", i, obs_b(), e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  cg;
        logic [14:0] e;
        go_sync();
        for (int i = 0; i < 24; i++) begin
            do begin
                cg = 10'($urandom_range(0, 1023));
            end while (cg[9:3] == 7'b0011111 || cg[9:3] == 7'b1100000);
            exp_q.push_back(ex(1'b1, 3'd0, (i % 2 == 0), cg));
            drive_in(1'b0, cg, 1'b0);
            e = exp_q.pop_front();
            n_total++;
            if (obs_a() !== e) $display("FAIL back_to_back[%0d]: got %h, expected %h", i, obs_a(), e);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass              = 0;
        n_total             = 0;
        RESET               = 1'b1;
        bus_a.rx_code_group = '0;
        bus_a.rx_invalid    = 1'b0;
        bus_b.rx_code_group = '0;
        bus_b.rx_invalid    = 1'b0;

        test_reset();
        test_acquire();
        test_bad_level();
        test_recovery();
        test_odd_comma();
        test_reset_sync();
        test_n1_build();
        test_back_to_back();

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
